// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding reads to the
// instruction memory and buffers returned words with their PCs in a small
// queue that feeds decode over a valid/ready handshake. Redirects flush all
// queued and in-flight work and restart fetch at the new PC.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    // instruction memory read master
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_gnt,
    input  logic [31:0] mem_rd_data,
    // redirect from execute
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    // toward decode
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] START_PC      = RESET_PC & PC_ALIGN_MASK;
    localparam logic [31:0] PC_STEP       = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    // fetch state
    logic [31:0]      pc_q;
    logic             inflight_q;
    logic [31:0]      inflight_pc_q;
    logic             drop_q;

    // fetch queue
    fq_entry_t        fq_mem [FQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // per-cycle events
    logic             pop_c;
    logic             push_c;
    logic             accept_c;
    logic [OCC_W-1:0] occ_c;
    logic [31:0]      redirect_pc_c;
    fq_entry_t        head_c;

    // Decode handshake: head is hidden in a redirect cycle so nothing pops.
    always_comb begin
        if_valid = 1'b0;
        pop_c    = 1'b0;
        head_c   = fq_mem[rd_ptr_q];
        if_pc    = '0;
        if_instr = '0;
        if (count_q != '0) begin
            if_valid = !redirect_valid;
            if_pc    = head_c.pc;
            if_instr = head_c.instr;
        end
        pop_c = if_valid && if_ready;
    end

    // Request side: only ask when the returning word is guaranteed a queue slot.
    always_comb begin
        occ_c       = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop_c);
        mem_rd_req  = !rst && !redirect_valid && (occ_c < OCC_W'(FQ_DEPTH));
        mem_rd_addr = pc_q;
        accept_c    = mem_rd_req && mem_rd_gnt;
    end

    // Response side: a returning word is kept unless a redirect squashes it.
    always_comb begin
        push_c        = inflight_q && !drop_q && !redirect_valid;
        redirect_pc_c = redirect_pc & PC_ALIGN_MASK;
    end

    // PC, in-flight tracking and queue bookkeeping; redirect overrides all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= START_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            drop_q        <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_pc_c;
            inflight_q <= 1'b0;
            drop_q     <= inflight_q;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            drop_q <= 1'b0;
            if (accept_c) begin
                pc_q          <= pc_q + PC_STEP;
                inflight_q    <= 1'b1;
                inflight_pc_q <= pc_q;
            end else begin
                inflight_q <= 1'b0;
            end
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop_c);
            wr_ptr_q <= wr_ptr_q + PTR_W'(push_c);
            count_q  <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Queue storage; contents are only observed through count_q so no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fq_mem[wr_ptr_q] <= '{pc: inflight_pc_q, instr: mem_rd_data};
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage. Owns the program counter, acts as read master on the instruction-memory dualport_bus (the instruction ROM is the slave), and buffers returned words with their PCs in a small queue that feeds decode over a valid/ready handshake. Accepts redirects (branch/jump) that flush all fetched and in-flight work.

## Interface
- RESET_PC, 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- FQ_DEPTH, 4: fetch-queue entries; power of two, ≥2.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_rd_req  out  1  read request to instruction memory (dualport_bus master side).
- mem_rd_addr  out  32  byte address of request; always word-aligned.
- mem_rd_gnt  in  1  grant; request accepted in a cycle where mem_rd_req & mem_rd_gnt.
- mem_rd_data  in  32  read data, valid exactly one cycle after the accepting cycle.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced to 0).
- if_valid  out  1  queue head valid toward decode.
- if_instr  out  32  instruction at queue head.
- if_pc  out  32  PC of if_instr.
- if_ready  in  1  decode accepts head when if_valid & if_ready.
- The memory-side ports (mem_rd_*) are the master-side read signals of dualport_bus; write-side signals of the bus are tied inactive (wr_req=0).

## Operation
- State: pc_q (next address to request), inflight_q (1 bit), inflight_pc_q, drop_q, fetch queue (FQ_DEPTH × {pc, instr}) with count.
- Credit: mem_rd_req = !rst & !redirect_valid & (count + inflight_q - pop < FQ_DEPTH), where pop = if_valid & if_ready. Request never exceeds queue space.
- mem_rd_addr = pc_q. Address held stable while mem_rd_req is high and not granted.
- Accept (req & gnt): pc_q <= pc_q + 4 (mod 2^32, 0xFFFF_FFFC wraps to 0); inflight_q <= 1; inflight_pc_q <= pc_q. Otherwise inflight_q <= 0.
- Response: when inflight_q & !drop_q, push {inflight_pc_q, mem_rd_data} into queue. At most one response outstanding (memory latency is exactly 1).
- Push and pop in the same cycle allowed at any occupancy; count unchanged.
- if_valid = (count != 0) & !redirect_valid; if_instr/if_pc = head entry, 0 when count = 0.
- Redirect (highest priority): queue cleared (count 0), pc_q <= {redirect_pc[31:2],2'b00}, no request issued that cycle, and any response arriving the next cycle is discarded (drop_q <= inflight_q). Response arriving in the redirect cycle itself is also discarded. A pop in the redirect cycle does not occur (if_valid forced low).
- Back-to-back redirects: last one wins; each restarts from its own PC.
- No decoding of instructions; a zero word from memory (out-of-range ROM address) is delivered as instruction 0x0000_0000 like any other.

## Timing
- Reset values: pc_q = RESET_PC, count = 0, inflight_q = 0, drop_q = 0; outputs mem_rd_req 0, mem_rd_addr RESET_PC, if_valid 0, if_instr 0, if_pc 0.
- First request in the first cycle after rst deasserts.
- Request accepted at cycle t → entry visible on if_valid at t+2 (data at t+1, registered into queue).
- Sustained throughput one instruction per cycle with if_ready high and gnt always high.
- Redirect at cycle t → request to redirect_pc at t+1, its instruction on if_valid at t+3.
- Reset asserted mid-operation: all state cleared immediately (asynchronous); pending response is lost; restart from RESET_PC.

## Test plan
- Straight-line: ROM with 0x00708093, 0x00710113, 0x002081b3, gnt=rd_req, if_ready=1 → decode sees (0x0,0x00708093),(0x4,0x00710113),(0x8,0x002081b3),(0xC,0x0), first at cycle 2 after reset release, one per cycle.
- Backpressure: if_ready=0 for 10 cycles → exactly FQ_DEPTH=4 entries fetched, mem_rd_req low afterwards, addr held at 0x10; on if_ready=1, PCs 0x0..0xC delivered in order, fetching resumes at 0x10, no loss or duplication.
- Grant stall: mem_rd_gnt=0 for 3 cycles at PC 0x8 → mem_rd_addr stable at 0x8, no push; after gnt, 0x8 delivered once.
- Redirect: redirect_valid with redirect_pc=0x0000_0006 while requests 0x8 in flight and queue non-empty → queue emptied, in-flight word dropped, next request 0x4, next if_pc 0x4 at redirect cycle+3.
- Wrap: RESET_PC=0xFFFF_FFF8 → requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in order.
- Reset mid-stream: assert rst with queue at 3 entries and one in flight → if_valid and mem_rd_req drop to 0 the same cycle; after release, fetch restarts at RESET_PC with no stale entries.
